// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
// MEM stage of the 5-stage RV32 pipeline. Holds the word-addressed data
// memory, performs the load/store of the instruction currently in M, and owns
// the M/W pipeline register that feeds writeback_cycle.
//
// Parameters:
//   DEPTH       number of 32-bit words in the data memory (power of two, >= 2)
//   ADDR_W      word-index width, $clog2(DEPTH)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset (clears M/W and memory)
//   RegWriteM    in   register-file write enable of the M instruction
//   MemWriteM    in   store enable
//   ResultSrcM   in   0 = ALU result, 1 = load data
//   RD_M         in   destination register
//   PCPlus4M     in   PC+4 of the M instruction
//   ALU_ResultM  in   effective address or ALU result
//   WriteDataM   in   store data
//   StallM       in   hold M/W and suppress the store
//   FlushW       in   load a bubble into M/W
//   RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
//                out  M/W pipeline register contents
//
// Optional build macro MEM_ACCESS_CNT_EN adds three 32-bit wrapping counters:
//   LoadCnt      out  loads that advanced out of M
//   StoreCnt     out  committed stores
//   MisalignCnt  out  loads/stores that advanced with ALU_ResultM[1:0] != 0
// -----------------------------------------------------------------------------
module memory_cycle #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic        StallM,
    input  logic        FlushW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [31:0] LoadCnt,
    output logic [31:0] StoreCnt,
    output logic [31:0] MisalignCnt
`endif
);

    // -------------------------------------------------------------------------
    // Data memory and addressing
    // -------------------------------------------------------------------------
    logic [31:0]       r_mem [DEPTH];

    // Word index: byte offset bits are dropped, upper bits alias (wrap).
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_data;
    logic              w_store_en;

    assign w_idx      = ALU_ResultM[ADDR_W+1:2];
    assign w_rd_data  = r_mem[w_idx];
    // A stalled instruction stays in M, so only its final (unstalled) cycle
    // commits the store; FlushW only affects M/W, not the store.
    assign w_store_en = MemWriteM && !StallM;

    // -------------------------------------------------------------------------
    // M/W pipeline register
    // -------------------------------------------------------------------------
    logic        r_reg_write_w;
    logic        r_result_src_w;
    logic [4:0]  r_rd_w;
    logic [31:0] r_pc_plus4_w;
    logic [31:0] r_alu_result_w;
    logic [31:0] r_read_data_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the memory is reset word by word because the pipeline
            // relies on a cleared data memory; this keeps it in flops rather
            // than a RAM macro, which has no multi-word clear.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 1'b0;
            r_rd_w         <= '0;
            r_pc_plus4_w   <= '0;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
        end else begin
            // NOTE: non-blocking assignments here mean ReadDataW below samples
            // the word as it was before this edge's store (read-old-data).
            if (w_store_en) begin
                r_mem[w_idx] <= WriteDataM;
            end

            if (FlushW) begin
                r_reg_write_w  <= 1'b0;
                r_result_src_w <= 1'b0;
                r_rd_w         <= '0;
                r_pc_plus4_w   <= '0;
                r_alu_result_w <= '0;
                r_read_data_w  <= '0;
            end else if (!StallM) begin
                r_reg_write_w  <= RegWriteM;
                r_result_src_w <= ResultSrcM;
                r_rd_w         <= RD_M;
                r_pc_plus4_w   <= PCPlus4M;
                r_alu_result_w <= ALU_ResultM;
                r_read_data_w  <= w_rd_data;
            end
        end
    end

    assign RegWriteW   = r_reg_write_w;
    assign ResultSrcW  = r_result_src_w;
    assign RD_W        = r_rd_w;
    assign PCPlus4W    = r_pc_plus4_w;
    assign ALU_ResultW = r_alu_result_w;
    assign ReadDataW   = r_read_data_w;

`ifdef MEM_ACCESS_CNT_EN
    // -------------------------------------------------------------------------
    // Access counters: count what leaves M, independent of FlushW; wrap freely.
    // -------------------------------------------------------------------------
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;
    logic [31:0] r_misalign_cnt;
    logic        w_misalign;

    assign w_misalign = (MemWriteM || ResultSrcM) && (ALU_ResultM[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt     <= '0;
            r_store_cnt    <= '0;
            r_misalign_cnt <= '0;
        end else if (!StallM) begin
            if (ResultSrcM) r_load_cnt     <= r_load_cnt + 32'd1;
            if (MemWriteM)  r_store_cnt    <= r_store_cnt + 32'd1;
            if (w_misalign) r_misalign_cnt <= r_misalign_cnt + 32'd1;
        end
    end

    assign LoadCnt     = r_load_cnt;
    assign StoreCnt    = r_store_cnt;
    assign MisalignCnt = r_misalign_cnt;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle
// Self-checking bench for memory_cycle (DEPTH = 1024). A behavioural model
// (array memory + expected M/W values) is updated on each rising edge from the
// applied inputs; one compare process checks every DUT output against it on
// the falling edge. Directed scenarios add literal expectations, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_memory_cycle;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM, FlushW;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] LoadCnt, StoreCnt, MisalignCnt;
`endif

    memory_cycle #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .StallM      (StallM),
        .FlushW      (FlushW),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .LoadCnt     (LoadCnt),
        .StoreCnt    (StoreCnt),
        .MisalignCnt (MisalignCnt)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    logic        e_rw, e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_pc, e_alu, e_rdata;
    logic [31:0] e_load_cnt, e_store_cnt, e_mis_cnt;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        int          idx;
        logic [31:0] old_word;
        idx      = int'(ALU_ResultM / 4) % DEPTH;
        old_word = m_mem[idx];
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 32'd0;
            {e_rw, e_rs, e_rd, e_pc, e_alu, e_rdata} = '0;
            e_load_cnt = 0; e_store_cnt = 0; e_mis_cnt = 0;
            model_valid = 1'b1;
        end else begin
            if (MemWriteM && !StallM) m_mem[idx] = WriteDataM;
            if (FlushW) begin
                {e_rw, e_rs, e_rd, e_pc, e_alu, e_rdata} = '0;
            end else if (!StallM) begin
                e_rw = RegWriteM; e_rs = ResultSrcM; e_rd = RD_M;
                e_pc = PCPlus4M;  e_alu = ALU_ResultM; e_rdata = old_word;
            end
            if (!StallM) begin
                if (ResultSrcM) e_load_cnt = e_load_cnt + 1;
                if (MemWriteM) e_store_cnt = e_store_cnt + 1;
                if ((MemWriteM || ResultSrcM) && (ALU_ResultM % 4 != 0)) e_mis_cnt = e_mis_cnt + 1;
            end
        end
    end

    // Single compare process, every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            check("w_ctrl", {RegWriteW, ResultSrcW, RD_W}, {e_rw, e_rs, e_rd});
            check("w_pc", PCPlus4W, e_pc);
            check("w_alu", ALU_ResultW, e_alu);
            check("w_rdata", ReadDataW, e_rdata);
`ifdef MEM_ACCESS_CNT_EN
            check("cnt", {LoadCnt, StoreCnt, MisalignCnt}, {e_load_cnt, e_store_cnt, e_mis_cnt});
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive(input logic rw, mw, rs, input logic [4:0] rd,
                         input logic [31:0] pc, alu, wd, input logic st, fl, r);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
        StallM = st; FlushW = fl; rst = r;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, addr, data, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic load(input logic [31:0] addr, input logic [4:0] rd);
        drive(1'b1, 1'b0, 1'b1, rd, 32'h1000 + addr, addr, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        // Reset with arbitrary inputs, including a store that must be dropped.
        drive(1'b1, 1'b1, 1'b1, 5'd17, 32'hFFFF_0000, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        step();
        check("rst_outputs", {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW}, 128'd0);
        load(32'h40, 5'd3);
        check("rst_mem_0x40", ReadDataW, 32'h0);

        // Store then load.
        store(32'h10, 32'hDEAD_BEEF);
        load(32'h10, 5'd5);
        check("st_ld_data", ReadDataW, 32'hDEAD_BEEF);
        check("st_ld_ctrl", {RegWriteW, ResultSrcW, RD_W}, {1'b1, 1'b1, 5'd5});

        // Wrap and alignment.
        store(32'h1000, 32'h1234);
        load(32'h0, 5'd6);
        check("wrap_0x1000", ReadDataW, 32'h1234);
        load(32'h3, 5'd6);
        check("align_0x3", ReadDataW, 32'h1234);

        // Read-during-write returns the old word.
        store(32'h10, 32'hA);
        drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h44, 32'h10, 32'hB, 1'b0, 1'b0, 1'b0);
        step();
        check("rdw_old", ReadDataW, 32'hA);
        load(32'h10, 5'd8);
        check("rdw_new", ReadDataW, 32'hB);

        // Stall: store is suppressed and M/W holds.
        store(32'h20, 32'h11);
        load(32'h44, 5'd7);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'h20, 32'h55, 1'b1, 1'b0, 1'b0);
            step();
            check("stall_hold_rd", RD_W, 5'd7);
        end
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h200, 32'h20, 32'h55, 1'b0, 1'b0, 1'b0);
        step();
        check("stall_rel_old", ReadDataW, 32'h11);
        check("stall_rel_w", {RD_W, PCPlus4W, ALU_ResultW}, {5'd9, 32'h200, 32'h20});
        load(32'h20, 5'd2);
        check("stall_commit", ReadDataW, 32'h55);

        // Flush over stall.
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h300, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        check("flush_stall", {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW}, 128'd0);

        // Mid-stream reset discards memory and M/W.
        store(32'h30, 32'h77);
        drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h400, 32'h30, 32'h99, 1'b0, 1'b0, 1'b1);
        step();
        check("midrst_w", {RegWriteW, RD_W, ALU_ResultW}, 128'd0);
        load(32'h30, 5'd4);
        check("midrst_mem", ReadDataW, 32'h0);

`ifdef MEM_ACCESS_CNT_EN
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        load(32'h1, 5'd1);
        load(32'h4, 5'd1);
        load(32'h6, 5'd1);
        check("cnt_load", LoadCnt, 32'd3);
        check("cnt_misalign", MisalignCnt, 32'd2);
        check("cnt_store", StoreCnt, 32'd0);
`endif

        // Randomized phase; small address set with aliasing high bits.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 15) << 2) | ($urandom & 32'h3) | (($urandom & 32'h1) << 12);
            drive(1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 5'($urandom),
                  $urandom, addr, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
MEM stage of the 5-stage RV32 pipeline. Holds the word-addressed data memory, performs loads and stores for the instruction in M, and owns the M/W pipeline register. Feeds writeback_cycle, which selects between ALU_ResultW and ReadDataW.

Parameters:
DEPTH, 1024, number of 32-bit words in the data memory; power of two, at least 2.
ADDR_W, $clog2(DEPTH), word-index width derived from DEPTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
RegWriteM  in  1  register-file write enable of the M instruction
MemWriteM  in  1  store enable
ResultSrcM  in  1  0 = ALU result, 1 = load data
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4 of the M instruction
ALU_ResultM  in  32  effective address, or ALU result
WriteDataM  in  32  store data
StallM  in  1  hold the M/W register and suppress the store
FlushW  in  1  load a bubble into the M/W register
RegWriteW  out  1  registered RegWriteM
ResultSrcW  out  1  registered ResultSrcM
RD_W  out  5  registered RD_M
PCPlus4W  out  32  registered PCPlus4M
ALU_ResultW  out  32  registered ALU_ResultM
ReadDataW  out  32  registered memory read data

Behaviour:
- Address: word index = ALU_ResultM[ADDR_W+1:2]. Bits [1:0] are ignored (word access only). Address bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH.
- Read: combinational from the array at the word index, every cycle, independent of ResultSrcM.
- Store: on a rising edge, mem[idx] <= WriteDataM when MemWriteM=1, StallM=0 and rst=0. The store is suppressed while StallM=1, so an instruction held in M stores exactly once. FlushW does not suppress the store.
- Read-during-write, same index, same cycle: ReadDataW captures the OLD word. The new word is visible to the next instruction.
- Priority on each rising edge: rst > FlushW > StallM > normal load.
- rst: every M/W output is cleared to 0 and every memory word is cleared to 0. The clear takes one cycle, and a store in that cycle is dropped. Reset asserted mid-stream discards the M/W contents and the memory contents.
- FlushW=1: RegWriteW=0, ResultSrcW=0, RD_W=0, PCPlus4W=0, ALU_ResultW=0, ReadDataW=0. This applies even when StallM=1.
- StallM=1, FlushW=0: all M/W outputs hold their value.
- Normal: all M/W outputs capture their M-side inputs, and ReadDataW captures the read data. Latency from M inputs to W outputs is 1 cycle.
- Writes to x0: RD_W and RegWriteW pass through unchanged. Masking x0 is the register file's job.

Optional Feature:
MEM_ACCESS_CNT_EN
- When defined, three extra outputs are added:
  - LoadCnt, out, 32: increments on each edge where ResultSrcM=1, StallM=0 and rst=0.
  - StoreCnt, out, 32: increments on each committed store.
  - MisalignCnt, out, 32: increments on each edge where (MemWriteM=1 or ResultSrcM=1), ALU_ResultM[1:0]!=0 and StallM=0.
- The counters wrap from 0xFFFFFFFF to 0, are cleared by rst, and are unaffected by FlushW.
- When not defined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=1 for 1 cycle with arbitrary inputs -> all W outputs are 0; a load from 0x40 afterwards returns ReadDataW=0.
- Store then load: store 0xDEADBEEF to 0x10, next cycle load from 0x10 with RD_M=5, RegWriteM=1, ResultSrcM=1 -> one cycle later ReadDataW=0xDEADBEEF, RD_W=5, RegWriteW=1, ResultSrcW=1.
- Wrap and alignment (DEPTH=1024): store 0x1234 to 0x1000, then load from 0x0000 -> 0x1234. Load from 0x0003 also returns the word at index 0.
- Read-during-write: mem[4]=0xA, then store 0xB to 0x10 with ResultSrcM=1 in the same cycle -> ReadDataW=0xA; a following load from 0x10 -> 0xB.
- Stall: StallM=1 for 3 cycles with MemWriteM=1 writing 0x55 to 0x20, after mem[8] was first set to 0x11 -> W outputs are held, mem[8] stays 0x11. Release the stall -> mem[8]=0x55 and W captures the M inputs.
- Flush over stall: StallM=1 and FlushW=1 together -> RegWriteW=0, all W buses 0. With MEM_ACCESS_CNT_EN, loads to 0x1, 0x4, 0x6 -> LoadCnt=3, MisalignCnt=2.
